// File: rtl/pid_pkg.sv
// Shared types, widths and saturation helpers for the PID term sequencer.
// Pure combinational helpers; no state, no flow control.
package pid_pkg;

   typedef enum logic [2:0] {IDLE, CALC_P, CALC_D, CALC_I, SUM} state_t;

   localparam int ERR_W   = 10;
   localparam int TERM_W  = 14;
   localparam int INTEG_W = 18;
   localparam int DIFF_W  = 9;
   localparam int PROD_W  = 17;

   function automatic logic signed [13:0] sat14(input logic signed [14:0] v);
      if (v[14] != v[13]) begin
         return v[14] ? 14'h2000 : 14'h1FFF;
      end
      return v[13:0];
   endfunction

   function automatic logic signed [8:0] sat9(input logic signed [10:0] v);
      if ((v[10:8] != 3'b000) && (v[10:8] != 3'b111)) begin
         return v[10] ? 9'h100 : 9'h0FF;
      end
      return v[8:0];
   endfunction

   // Clamp a full multiplier product into the 14-bit term range.
   function automatic logic signed [13:0] sat_prod14(input logic signed [16:0] v);
      if ((v[16:13] != 4'b0000) && (v[16:13] != 4'b1111)) begin
         return v[16] ? 14'h2000 : 14'h1FFF;
      end
      return v[13:0];
   endfunction

endpackage

// File: rtl/pid_shared_mult.sv
// Single signed 10x7 multiplier with its operand mux: error*P gain or diff*D gain.
// Combinational, zero latency, no flow control.
module pid_shared_mult
   import pid_pkg::*;
#(
   parameter logic [5:0] P_COEFF = 6'h05,
   parameter logic [4:0] D_COEFF = 5'h07
) (
   input  logic                     sel_d,
   input  logic signed [ERR_W-1:0]  err,
   input  logic signed [DIFF_W-1:0] diff,
   output logic signed [PROD_W-1:0] prod
);

   logic signed [ERR_W-1:0] op_a;
   logic signed [6:0]       op_b;

   always_comb begin
      op_a = err;
      op_b = {1'b0, P_COEFF};
      if (sel_d) begin
         op_a = {diff[DIFF_W-1], diff};
         op_b = {2'b00, D_COEFF};
      end
   end

   assign prod = op_a * op_b;

endmodule

// File: rtl/pid_term_sched.sv
// Sequences P, D and I work through one shared multiplier; result 5 edges after err_vld.
// Never stalls the source: one sample is held pending while busy, later ones overwrite it.
module pid_term_sched
   import pid_pkg::*;
#(
   parameter logic [5:0] P_COEFF       = 6'h05,
   parameter logic [4:0] D_COEFF       = 5'h07,
   parameter int         D_QUEUE_DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     err_vld,
   input  logic signed [ERR_W-1:0]  err_sat,
   input  logic                     moving,
   output logic                     pid_vld,
   output logic signed [TERM_W-1:0] PID,
   output logic                     busy,
   output logic                     overrun
);

   state_t                    state_q, state_d;
   logic signed [ERR_W-1:0]   err_q, err_d;
   logic signed [ERR_W-1:0]   pend_q, pend_d;
   logic                      pending_q, pending_d;
   logic                      overrun_q, overrun_d;
   logic signed [TERM_W-1:0]  p_q, p_d;
   logic signed [TERM_W-1:0]  d_q, d_d;
   logic signed [INTEG_W-1:0] integ_q, integ_d;
   logic signed [TERM_W-1:0]  pid_q, pid_d;
   logic                      pid_vld_q, pid_vld_d;
   logic signed [ERR_W-1:0]   queue_q [D_QUEUE_DEPTH];
   logic signed [ERR_W-1:0]   queue_d [D_QUEUE_DEPTH];

   logic signed [ERR_W-1:0]   oldest;
   logic signed [ERR_W:0]     diff_full;
   logic signed [DIFF_W-1:0]  diff_sat;
   logic signed [PROD_W-1:0]  prod;
   logic signed [INTEG_W-1:0] integ_sum;
   logic                      integ_ovf;
   logic signed [TERM_W:0]    sum15;

   assign oldest    = queue_q[D_QUEUE_DEPTH-1];
   assign diff_full = {err_q[ERR_W-1], err_q} - {oldest[ERR_W-1], oldest};
   assign diff_sat  = sat9(diff_full);

   pid_shared_mult #(
      .P_COEFF (P_COEFF),
      .D_COEFF (D_COEFF)
   ) u_mult (
      .sel_d (state_q == CALC_D),
      .err   (err_q),
      .diff  (diff_sat),
      .prod  (prod)
   );

   // Overflow only possible when both operands share a sign and the result flips it.
   assign integ_sum = integ_q + {{(INTEG_W-ERR_W){err_q[ERR_W-1]}}, err_q};
   assign integ_ovf = (integ_q[INTEG_W-1] == err_q[ERR_W-1]) &&
                      (integ_sum[INTEG_W-1] != integ_q[INTEG_W-1]);

   assign sum15 = {p_q[TERM_W-1], p_q}
                + {{3{integ_q[INTEG_W-1]}}, integ_q[INTEG_W-1:6]}
                + {d_q[TERM_W-1], d_q};

   always_comb begin
      state_d   = state_q;
      err_d     = err_q;
      pend_d    = pend_q;
      pending_d = pending_q;
      overrun_d = overrun_q;
      p_d       = p_q;
      d_d       = d_q;
      integ_d   = integ_q;
      pid_d     = pid_q;
      pid_vld_d = 1'b0;
      for (int i = 0; i < D_QUEUE_DEPTH; i++) begin
         queue_d[i] = queue_q[i];
      end

      case (state_q)
         IDLE: begin
            if (pending_q) begin
               err_d     = pend_q;
               pending_d = 1'b0;
               state_d   = CALC_P;
               if (err_vld) begin
                  pend_d    = err_sat;
                  pending_d = 1'b1;
               end
            end else if (err_vld) begin
               err_d   = err_sat;
               state_d = CALC_P;
            end
         end
         CALC_P: begin
            p_d     = sat_prod14(prod);
            state_d = CALC_D;
         end
         CALC_D: begin
            d_d        = prod[TERM_W-1:0];
            queue_d[0] = err_q;
            for (int i = 1; i < D_QUEUE_DEPTH; i++) begin
               queue_d[i] = queue_q[i-1];
            end
            state_d = CALC_I;
         end
         CALC_I: begin
            if (!moving) begin
               integ_d = '0;
            end else if (!integ_ovf) begin
               integ_d = integ_sum;
            end
            state_d = SUM;
         end
         SUM: begin
            pid_d     = sat14(sum15);
            pid_vld_d = 1'b1;
            if (pending_q) begin
               err_d     = pend_q;
               pending_d = 1'b0;
               state_d   = CALC_P;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // In SUM the pending slot is being drained this edge, so a new sample is not an overrun.
      if (err_vld && (state_q != IDLE)) begin
         pend_d    = err_sat;
         pending_d = 1'b1;
         if (pending_q && (state_q != SUM)) begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         err_q     <= '0;
         pend_q    <= '0;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
         p_q       <= '0;
         d_q       <= '0;
         integ_q   <= '0;
         pid_q     <= '0;
         pid_vld_q <= 1'b0;
         for (int i = 0; i < D_QUEUE_DEPTH; i++) begin
            queue_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         err_q     <= err_d;
         pend_q    <= pend_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
         p_q       <= p_d;
         d_q       <= d_d;
         integ_q   <= integ_d;
         pid_q     <= pid_d;
         pid_vld_q <= pid_vld_d;
         for (int i = 0; i < D_QUEUE_DEPTH; i++) begin
            queue_q[i] <= queue_d[i];
         end
      end
   end

   assign pid_vld = pid_vld_q;
   assign PID     = pid_q;
   assign busy    = (state_q != IDLE);
   assign overrun = overrun_q;

endmodule

// File: tb/tb_pid_term_sched.sv
// Directed bench for pid_term_sched with hand-computed PID values (P=5, D=7, depth 2).
module tb_pid_term_sched;

   logic               clk     = 1'b0;
   logic               rst_n   = 1'b1;
   logic               err_vld = 1'b0;
   logic signed [9:0]  err_sat = '0;
   logic               moving  = 1'b1;
   logic               pid_vld;
   logic signed [13:0] PID;
   logic               busy;
   logic               overrun;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   pid_term_sched dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .err_vld (err_vld),
      .err_sat (err_sat),
      .moving  (moving),
      .pid_vld (pid_vld),
      .PID     (PID),
      .busy    (busy),
      .overrun (overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic send(input logic signed [9:0] v);
      @(negedge clk);
      err_vld = 1'b1;
      err_sat = v;
      @(negedge clk);
      err_vld = 1'b0;
   endtask

   // Returns number of negedges until pid_vld is seen; ok=0 if the budget expires.
   task automatic wait_pid(input int budget, output int lat, output logic ok);
      lat = 0;
      ok  = 1'b0;
      for (int i = 1; i <= budget; i++) begin
         @(negedge clk);
         if (pid_vld === 1'b1) begin
            lat = i;
            ok  = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (PID !== 14'sd0) begin n_fail++; $display("FAIL reset_pid: got %0d want 0", PID); end
      n_cmp++; if (pid_vld !== 1'b0) begin n_fail++; $display("FAIL reset_pid_vld: got %b want 0", pid_vld); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
      rst_n = 1'b1;
   endtask

   task automatic test_single();
      int   lat;
      logic ok;
      send(10'sd40);
      n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
      wait_pid(20, lat, ok);
      n_cmp++; if (!ok || lat != 4) begin n_fail++; $display("FAIL single_latency: got %0d want 4", lat); end
      n_cmp++; if (PID !== 14'sd480) begin n_fail++; $display("FAIL single_pid: got %0d want 480", PID); end
      @(negedge clk);
      n_cmp++; if (pid_vld !== 1'b0) begin n_fail++; $display("FAIL single_strobe_width: got %b want 0", pid_vld); end
   endtask

   task automatic test_repeat();
      int   lat;
      logic ok;
      logic signed [13:0] exp_tab [2];
      exp_tab[0] = 14'sd481;
      exp_tab[1] = 14'sd201;
      for (int s = 0; s < 2; s++) begin
         repeat (3) @(negedge clk);
         send(10'sd40);
         wait_pid(20, lat, ok);
         n_cmp++;
         if (!ok || PID !== exp_tab[s]) begin
            n_fail++;
            $display("FAIL repeat_pid%0d: got %0d want %0d", s, PID, exp_tab[s]);
         end
      end
   endtask

   task automatic test_diff_sat();
      int   lat;
      logic ok;
      do_reset();
      moving = 1'b0;
      send(-10'sd512);
      wait_pid(20, lat, ok);
      n_cmp++; if (!ok || PID !== -14'sd4352) begin n_fail++; $display("FAIL diff_sat_pid: got %0d want -4352", PID); end
      moving = 1'b1;
   endtask

   task automatic test_integ_sat();
      int   lat;
      logic ok;
      logic signed [13:0] pid255, pid256;
      pid255 = '0;
      pid256 = '0;
      do_reset();
      for (int s = 1; s <= 257; s++) begin
         send(10'sd511);
         wait_pid(20, lat, ok);
         if (!ok) begin
            n_cmp++; n_fail++;
            $display("FAIL integ_timeout: sample %0d got no pid_vld want pulse", s);
            break;
         end
         if (s == 255) pid255 = PID;
         if (s == 256) pid256 = PID;
      end
      n_cmp++; if (pid255 !== 14'sd4591) begin n_fail++; $display("FAIL integ_255: got %0d want 4591", pid255); end
      n_cmp++; if (pid256 !== 14'sd4599) begin n_fail++; $display("FAIL integ_256: got %0d want 4599", pid256); end
      n_cmp++; if (PID !== 14'sd4599) begin n_fail++; $display("FAIL integ_257_hold: got %0d want 4599", PID); end
      n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL integ_overrun: got %b want 0", overrun); end
   endtask

   task automatic test_back_to_back();
      int   lat;
      logic ok;
      int   c1, c2;
      c1 = 0;
      do_reset();
      @(negedge clk); err_vld = 1'b1; err_sat = 10'sd40;
      @(negedge clk); err_sat = 10'sd100;
      @(negedge clk); err_sat = -10'sd20;
      @(negedge clk); err_vld = 1'b0;
      wait_pid(20, lat, ok);
      c1 = cyc;
      n_cmp++; if (!ok || PID !== 14'sd480) begin n_fail++; $display("FAIL b2b_first: got %0d want 480", PID); end
      wait_pid(20, lat, ok);
      c2 = cyc;
      n_cmp++; if (!ok || PID !== -14'sd240) begin n_fail++; $display("FAIL b2b_third: got %0d want -240", PID); end
      n_cmp++; if (c2 - c1 != 4) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 4", c2 - c1); end
      n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL b2b_overrun: got %b want 1", overrun); end
      wait_pid(12, lat, ok);
      n_cmp++; if (ok !== 1'b0) begin n_fail++; $display("FAIL b2b_extra_pulse: got pulse at %0d want none", lat); end
   endtask

   task automatic test_reset_mid();
      int   lat;
      logic ok;
      send(10'sd40);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (PID !== 14'sd0) begin n_fail++; $display("FAIL mid_pid: got %0d want 0", PID); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
      n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL mid_overrun: got %b want 0", overrun); end
      n_cmp++; if (pid_vld !== 1'b0) begin n_fail++; $display("FAIL mid_pid_vld: got %b want 0", pid_vld); end
      @(negedge clk);
      rst_n = 1'b1;
      wait_pid(12, lat, ok);
      n_cmp++; if (ok !== 1'b0) begin n_fail++; $display("FAIL mid_stray_pulse: got pulse at %0d want none", lat); end
      send(10'sd40);
      wait_pid(20, lat, ok);
      n_cmp++; if (!ok || PID !== 14'sd480) begin n_fail++; $display("FAIL mid_restart: got %0d want 480", PID); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_repeat();
      test_diff_sat();
      test_integ_sat();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
